inv_power_reduce: RTL and testbench
===================================

// Module: inv_power_reduce
// PURPOSE
//  Correction stage paired with the almost-inverse engine. Consumes value = a^-1 * 2^power mod p
//  and its power, then strips the 2^power factor by repeated modular halving.
//  Produces a^-1 * 2^R_POW mod p: R_POW=0 gives the plain inverse, R_POW=`BW_GF the Montgomery form.
//  Sits between the inverse engine and the ECDH point-arithmetic datapath.
// PARAMETERS
//  PAD    2  extra headroom bits on the internal accumulator; (x+p) needs >= 1
//  R_POW  0  target power of 2 kept in the result; must be < 512
// PORTS
//  clk    input   1         rising-edge clock
//  rst    input   1         synchronous, active-high reset
//  en     input   1         start pulse, sampled only in IDLE; driven by the engine's valid
//  value  input   `BW_GF    almost-inverse r; may equal p
//  power  input   9         exponent k from the engine
//  inv    output  `BW_GF    result; holds until the next result or reset
//  valid  output  1         1-cycle pulse when inv/err are updated
//  err    output  1         set with valid when power < R_POW; cleared on the next start
//  busy   output  1         high from the cycle after an accepted en until the valid cycle, inclusive
// BEHAVIOUR
//  Reset: state=IDLE; inv=0, valid=0, err=0, busy=0; internal x and cnt cleared.
//  Internal width BW=`BW_GF+PAD, unsigned; p=`PRIME zero-extended.
//  IDLE, en=1 (edge E0):
//   - x <= (value >= p) ? value-p : value.
//   - power < R_POW: go to FAIL; err and valid rise at E1; inv <= 0.
//   - cnt == 0: go to DONE; valid and busy high at E1; inv <= x.
//   - otherwise: cnt <= power-R_POW, go to HALVE.
//  HALVE, one step per clock:
//   - x <= x[0] ? (x+p)>>1 : x>>1; cnt <= cnt-1.
//   - The result stays in [0,p-1] with no final subtract, since x < p is kept.
//   - On the step where cnt==1, go to DONE.
//  DONE/FAIL, one cycle: valid=1; inv <= x[`BW_GF-1:0] (FAIL: 0); next state IDLE.
//  Latency: valid is asserted exactly (power-R_POW)+1 cycles after the en edge; FAIL takes 1 cycle.
//  Throughput: a new en is accepted in the first IDLE cycle after valid (back-to-back gap of 1).
//  en while busy is ignored: no queuing, and no change to x, cnt, inv or err.
//  en in the same cycle as rst: rst wins; the block is IDLE next cycle and the request is dropped.
//  rst mid-operation: aborts, no valid pulse, outputs return to reset values.
//  value=0: result 0 after the full latency. power=511: legal, 511-R_POW halvings.
//  valid is never high two cycles in a row; busy=0 in IDLE only.
// TESTING  (test build: `BW_GF=8, `PRIME=251, PAD=2, R_POW=0 unless noted)
//  1 value=1, power=1 -> valid 2 cycles after en; inv=126 (126*2 mod 251 = 1); err=0.
//  2 value=4, power=2 -> 4->2->1; inv=1, valid at +3; busy high for exactly 3 cycles.
//  3 value=200, power=0 -> inv=200 at +1; then value=251, power=3 -> inv=0 at +4.
//  4 R_POW=8 build: power=5 -> err=1, valid at +1, inv=0; next power=9, value=2 -> err=0, inv=1.
//  5 en pulsed every cycle during a power=10 run -> exactly one valid; inputs during busy ignored;
//    rst asserted mid-run -> no valid, outputs 0.
//  6 Chained with the inverse engine, 1000 random a in [1,250] -> inv*a mod 251 == 1 for every a.

Source files
------------

// File: rtl/inv_power_reduce.sv
// Strips the 2^power factor from an almost-inverse by repeated modular halving,
// leaving a^-1 * 2^R_POW mod p on inv with a one-cycle valid pulse.
`ifndef BW_GF
`define BW_GF 8
`endif
`ifndef PRIME
`define PRIME 251
`endif

module inv_power_reduce #(
   parameter int PAD   = 2,
   parameter int R_POW = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [`BW_GF-1:0] value,
   input  logic [8:0]        power,
   output logic [`BW_GF-1:0] inv,
   output logic              valid,
   output logic              err,
   output logic              busy
);

   localparam int BW = `BW_GF + PAD;
   localparam logic [BW-1:0] P  = BW'(`PRIME);
   localparam logic [9:0]    RP = 10'(R_POW);

   typedef enum logic [1:0] {S_IDLE, S_HALVE, S_DONE, S_FAIL} state_t;

   state_t            state_reg, state_next;
   logic [BW-1:0]     x_reg, x_next;
   logic [8:0]        cnt_reg, cnt_next;
   logic [`BW_GF-1:0] inv_reg, inv_next;
   logic              err_reg, err_next;

   logic [BW-1:0]     value_ext, value_red, x_half;
   logic [9:0]        diff;

   assign value_ext = BW'(value);
   assign value_red = (value_ext >= P) ? value_ext - P : value_ext;
   // x < p holds throughout, so (x+p)/2 < p and no final correction is needed.
   assign x_half    = x_reg[0] ? ((x_reg + P) >> 1) : (x_reg >> 1);
   assign diff      = {1'b0, power} - RP;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_IDLE;
         x_reg     <= '0;
         cnt_reg   <= '0;
         inv_reg   <= '0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         x_reg     <= x_next;
         cnt_reg   <= cnt_next;
         inv_reg   <= inv_next;
         err_reg   <= err_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      x_next     = x_reg;
      cnt_next   = cnt_reg;
      inv_next   = inv_reg;
      err_next   = err_reg;
      case (state_reg)
         S_IDLE: begin
            if (en) begin
               x_next   = value_red;
               err_next = 1'b0;
               if ({1'b0, power} < RP) begin
                  state_next = S_FAIL;
                  inv_next   = '0;
                  err_next   = 1'b1;
               end else if (diff == 10'd0) begin
                  state_next = S_DONE;
                  inv_next   = `BW_GF'(value_red);
               end else begin
                  cnt_next   = diff[8:0];
                  state_next = S_HALVE;
               end
            end
         end
         S_HALVE: begin
            x_next   = x_half;
            cnt_next = cnt_reg - 9'd1;
            // Result is published on entry to DONE so inv is stable while valid is high.
            if (cnt_reg == 9'd1) begin
               state_next = S_DONE;
               inv_next   = `BW_GF'(x_half);
            end
         end
         S_DONE:  state_next = S_IDLE;
         S_FAIL:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   assign inv   = inv_reg;
   assign err   = err_reg;
   assign valid = (state_reg == S_DONE) || (state_reg == S_FAIL);
   assign busy  = (state_reg != S_IDLE);

endmodule

// File: tb/tb_inv_power_reduce.sv
// Directed-vector bench for inv_power_reduce: a plain-inverse instance (R_POW=0)
// and a Montgomery-form instance (R_POW=8) share clock and reset.
`timescale 1ns/1ps

module tb_inv_power_reduce;

   logic       clk = 1'b0;
   logic       rst;
   logic       en0, en8;
   logic [7:0] value0, value8;
   logic [8:0] power0, power8;
   logic [7:0] inv0, inv8;
   logic       valid0, valid8, err0, err8, busy0, busy8;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   inv_power_reduce #(.PAD(2), .R_POW(0)) dut0 (
      .clk(clk), .rst(rst), .en(en0), .value(value0), .power(power0),
      .inv(inv0), .valid(valid0), .err(err0), .busy(busy0));

   inv_power_reduce #(.PAD(2), .R_POW(8)) dut8 (
      .clk(clk), .rst(rst), .en(en8), .value(value8), .power(power8),
      .inv(inv8), .valid(valid8), .err(err8), .busy(busy8));

   typedef struct {
      int   sel;
      logic [7:0] value;
      logic [8:0] power;
      int   exp_inv;
      int   exp_err;
      int   exp_lat;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge on which valid is seen.
   task automatic run(input int sel, input logic [7:0] v, input logic [8:0] pw,
                      output int o_inv, output int o_err, output int lat, output int bcnt);
      logic done;
      done = 1'b0; lat = 0; bcnt = 0; o_inv = -1; o_err = -1;
      if (sel == 0) begin value0 = v; power0 = pw; en0 = 1'b1; end
      else          begin value8 = v; power8 = pw; en8 = 1'b1; end
      while (!done && lat < 600) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         en0 = 1'b0; en8 = 1'b0;
         if (sel == 0 ? busy0 : busy8) bcnt++;
         if (sel == 0 ? valid0 : valid8) begin
            done  = 1'b1;
            o_inv = (sel == 0) ? int'(inv0) : int'(inv8);
            o_err = (sel == 0) ? int'(err0) : int'(err8);
         end
      end
      if (!done) lat = -1;
   endtask

   function automatic int modinv(input int a);
      for (int i = 1; i < 251; i++) if ((a * i) % 251 == 1) return i;
      return 0;
   endfunction

   vec_t vecs[12];

   initial begin
      int o_inv, o_err, lat, bcnt, vcount;
      vecs[0]  = '{0,   8'd1,   9'd1, 126, 0,  2};
      vecs[1]  = '{0,   8'd4,   9'd2,   1, 0,  3};
      vecs[2]  = '{0, 8'd200,   9'd0, 200, 0,  1};
      vecs[3]  = '{0, 8'd251,   9'd3,   0, 0,  4};
      vecs[4]  = '{0,   8'd0,   9'd5,   0, 0,  6};
      vecs[5]  = '{0,   8'd3,   9'd1, 127, 0,  2};
      vecs[6]  = '{0, 8'd253,   9'd0,   2, 0,  1};
      vecs[7]  = '{0,   8'd1,   9'd8, 201, 0,  9};
      vecs[8]  = '{8,   8'd9,   9'd5,   0, 1,  1};
      vecs[9]  = '{8,   8'd2,   9'd9,   1, 0,  2};
      vecs[10] = '{8,   8'd7,   9'd8,   7, 0,  1};
      vecs[11] = '{0, 8'd10, 9'd511, (10 * 126) % 251, 0, 512};
      // 2^-511 mod 251: 2^250 = 1, so 2^-511 = 2^-11 = 2^-10 * 2^-1 = 113*126 mod 251.
      vecs[11].exp_inv = (10 * ((113 * 126) % 251)) % 251;

      rst = 1'b1; en0 = 0; en8 = 0; value0 = 0; value8 = 0; power0 = 0; power8 = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_inv0", inv0, 0);   chk("reset_valid0", valid0, 0);
      chk("reset_err0", err0, 0);   chk("reset_busy0", busy0, 0);
      chk("reset_inv8", inv8, 0);   chk("reset_err8", err8, 0);
      rst = 1'b0;
      @(negedge clk);

      foreach (vecs[i]) begin
         run(vecs[i].sel, vecs[i].value, vecs[i].power, o_inv, o_err, lat, bcnt);
         $display("vec %0d: dut%0d value=%0d power=%0d -> inv=%0d err=%0d lat=%0d busy=%0d",
                  i, vecs[i].sel, vecs[i].value, vecs[i].power, o_inv, o_err, lat, bcnt);
         chk($sformatf("vec%0d_inv", i), o_inv, vecs[i].exp_inv);
         chk($sformatf("vec%0d_err", i), o_err, vecs[i].exp_err);
         chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
         chk($sformatf("vec%0d_busy_cycles", i), bcnt, vecs[i].exp_lat);
         @(negedge clk);
         chk($sformatf("vec%0d_valid_pulse", i), vecs[i].sel == 0 ? valid0 : valid8, 0);
         chk($sformatf("vec%0d_idle_busy", i), vecs[i].sel == 0 ? busy0 : busy8, 0);
      end

      // en held high and inputs churned throughout a power=10 run: only the first is taken.
      value0 = 8'd5; power0 = 9'd10; en0 = 1'b1;
      lat = 0; vcount = 0; o_inv = -1;
      while (vcount == 0 && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         value0 = 8'($urandom_range(0, 255));
         power0 = 9'($urandom_range(0, 3));
         if (valid0) begin vcount++; o_inv = int'(inv0); en0 = 1'b0; end
      end
      repeat (4) begin
         @(negedge clk);
         if (valid0) vcount++;
      end
      $display("en_storm: inv=%0d lat=%0d valids=%0d", o_inv, lat, vcount);
      chk("en_storm_inv", o_inv, 63);
      chk("en_storm_latency", lat, 11);
      chk("en_storm_valid_count", vcount, 1);

      // Leave err set on dut8, then reset dut0 mid-run; everything returns to zero.
      run(8, 8'd1, 9'd2, o_inv, o_err, lat, bcnt);
      chk("pre_reset_err8", o_err, 1);
      @(negedge clk);
      run(0, 8'd1, 9'd1, o_inv, o_err, lat, bcnt);
      @(negedge clk);
      value0 = 8'd7; power0 = 9'd10; en0 = 1'b1;
      @(negedge clk);
      en0 = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrun_rst_inv0", inv0, 0);
      chk("midrun_rst_busy0", busy0, 0);
      chk("midrun_rst_err8", err8, 0);
      vcount = 0;
      repeat (15) begin
         @(negedge clk);
         if (valid0) vcount++;
      end
      $display("midrun_rst: valids_after=%0d inv0=%0d", vcount, inv0);
      chk("midrun_rst_no_valid", vcount, 0);

      // en coincident with rst is dropped.
      value0 = 8'd4; power0 = 9'd0; en0 = 1'b1; rst = 1'b1;
      @(negedge clk);
      en0 = 1'b0; rst = 1'b0;
      chk("en_with_rst_busy", busy0, 0);
      vcount = 0;
      repeat (4) begin
         @(negedge clk);
         if (valid0) vcount++;
      end
      $display("en_with_rst: valids=%0d", vcount);
      chk("en_with_rst_no_valid", vcount, 0);

      // Emulated engine output r = a^-1 * 2^k mod p for random a, k.
      for (int t = 0; t < 40; t++) begin
         int a, ai, k, r, exp8;
         a  = $urandom_range(1, 250);
         ai = modinv(a);
         k  = $urandom_range(8, 30);
         r  = ai;
         for (int j = 0; j < k; j++) r = (r * 2) % 251;
         exp8 = (ai * 256) % 251;
         run(0, 8'(r), 9'(k), o_inv, o_err, lat, bcnt);
         $display("rand %0d: a=%0d k=%0d r=%0d dut0 inv=%0d lat=%0d", t, a, k, r, o_inv, lat);
         chk($sformatf("rand%0d_inverse_product", t), (o_inv * a) % 251, 1);
         chk($sformatf("rand%0d_latency", t), lat, k + 1);
         @(negedge clk);
         run(8, 8'(r), 9'(k), o_inv, o_err, lat, bcnt);
         $display("rand %0d: a=%0d k=%0d r=%0d dut8 inv=%0d lat=%0d", t, a, k, r, o_inv, lat);
         chk($sformatf("rand%0d_mont", t), o_inv, exp8);
         @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
